// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, ALU
// encodings, instruction field positions, phase strobe patterns and the
// phase sequencer state encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int ERRC_W_DEF = 4;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_LDI  = 4'h4;
  localparam logic [3:0] OPC_JMP  = 4'h5;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;

  // Strobe vector is packed as {fsm3, fsm2, fsm1, fsm0}.
  localparam logic [3:0] STB_F = 4'b0001;
  localparam logic [3:0] STB_D = 4'b0010;
  localparam logic [3:0] STB_E = 4'b0100;
  localparam logic [3:0] STB_W = 4'b1000;

  typedef enum logic [1:0] {
    WAIT_F = 2'd0,
    EXP_D  = 2'd1,
    EXP_E  = 2'd2,
    EXP_W  = 2'd3
  } phase_state_t;

  // The single strobe that is legal in a given state.
  function automatic logic [3:0] expected_strobe(input phase_state_t s);
    logic [3:0] r;
    case (s)
      WAIT_F:  r = STB_F;
      EXP_D:   r = STB_D;
      EXP_E:   r = STB_E;
      default: r = STB_W;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: splits the instruction register
// into register addresses and ALU/write-back controls, and flags opcodes
// outside the defined set. Illegal opcodes decode with all side effects off
// so they behave as NOP.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] ir,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [3:0]        wa,
  output logic [1:0]        alu_op,
  output logic              imm_sel,
  output logic              wb_en,
  output logic              is_jmp,
  output logic              is_halt,
  output logic              illegal
);

  logic [3:0] opc;

  assign opc = ir[OPC_LSB +: 4];
  assign ra  = ir[RS_LSB +: 4];
  assign rb  = ir[RT_LSB +: 4];
  assign wa  = ir[RD_LSB +: 4];

  // Map the opcode to ALU function, operand select and side-effect flags.
  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = 1'b0;
    wb_en   = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (opc)
      OPC_NOP: ;
      OPC_ADD: begin alu_op = ALU_ADD; wb_en = 1'b1; end
      OPC_SUB: begin alu_op = ALU_SUB; wb_en = 1'b1; end
      OPC_AND: begin alu_op = ALU_AND; wb_en = 1'b1; end
      OPC_LDI: begin alu_op = ALU_PASSB; imm_sel = 1'b1; wb_en = 1'b1; end
      OPC_JMP: is_jmp = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer for the multi-cycle CPU. Tracks the four one-hot phase
// strobes, owns PC and IR, registers decode controls for the datapath and
// resynchronises to fetch whenever the strobe protocol is broken.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ERRC_W = ERRC_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fsm0,
  input  logic              fsm1,
  input  logic              fsm2,
  input  logic              fsm3,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] ir_q,
  output logic [3:0]        rf_ra,
  output logic [3:0]        rf_rb,
  output logic [3:0]        rf_wa,
  output logic              rf_we,
  output logic [1:0]        alu_op,
  output logic              imm_sel,
  output logic              halted,
  output logic              illegal,
  output logic              phase_err,
  output logic [ERRC_W-1:0] err_cnt
);

  phase_state_t state, state_nxt;

  logic [ADDR_W-1:0] pc;
  logic [3:0]        strobes;
  logic              violation;
  logic              do_fetch;
  logic              do_decode;
  logic              do_wb;

  logic [3:0] dec_ra, dec_rb, dec_wa;
  logic [1:0] dec_alu_op;
  logic       dec_imm_sel, dec_wb_en, dec_is_jmp, dec_is_halt, dec_illegal;

  logic wb_en_q, jmp_q, halt_q;

  assign strobes   = {fsm3, fsm2, fsm1, fsm0};
  assign imem_addr = pc;

  instr_decode #(.DATA_W(DATA_W)) u_decode (
    .ir      (ir_q),
    .ra      (dec_ra),
    .rb      (dec_rb),
    .wa      (dec_wa),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel),
    .wb_en   (dec_wb_en),
    .is_jmp  (dec_is_jmp),
    .is_halt (dec_is_halt),
    .illegal (dec_illegal)
  );

  // Next state plus per-edge action strobes; a lone unexpected fetch is
  // still taken so the sequencer resynchronises without losing a cycle.
  always_comb begin
    state_nxt = state;
    violation = 1'b0;
    do_fetch  = 1'b0;
    do_decode = 1'b0;
    do_wb     = 1'b0;
    if (!halted && strobes != 4'b0000) begin
      if (strobes == expected_strobe(state)) begin
        case (state)
          WAIT_F:  begin do_fetch  = 1'b1; state_nxt = EXP_D; end
          EXP_D:   begin do_decode = 1'b1; state_nxt = EXP_E; end
          EXP_E:   state_nxt = EXP_W;
          default: begin do_wb     = 1'b1; state_nxt = WAIT_F; end
        endcase
      end else begin
        violation = 1'b1;
        if (strobes == STB_F) begin
          do_fetch  = 1'b1;
          state_nxt = EXP_D;
        end else begin
          state_nxt = WAIT_F;
        end
      end
    end
  end

  // Phase state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= WAIT_F;
    else         state <= state_nxt;
  end

  // Instruction register, program counter and the sticky halt flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir_q   <= '0;
      pc     <= '0;
      halted <= 1'b0;
    end else begin
      if (do_fetch) ir_q <= imem_data;
      if (do_wb) begin
        if (jmp_q)       pc <= ADDR_W'(ir_q[7:0]);
        else if (halt_q) halted <= 1'b1;
        else             pc <= pc + ADDR_W'(1);
      end
    end
  end

  // Decode controls captured in the decode phase and held for the datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_ra   <= '0;
      rf_rb   <= '0;
      rf_wa   <= '0;
      alu_op  <= ALU_ADD;
      imm_sel <= 1'b0;
      wb_en_q <= 1'b0;
      jmp_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else if (do_decode) begin
      rf_ra   <= dec_ra;
      rf_rb   <= dec_rb;
      rf_wa   <= dec_wa;
      alu_op  <= dec_alu_op;
      imm_sel <= dec_imm_sel;
      wb_en_q <= dec_wb_en;
      jmp_q   <= dec_is_jmp;
      halt_q  <= dec_is_halt;
    end
  end

  // Single-cycle pulses: write enable, illegal opcode and protocol error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we     <= 1'b0;
      illegal   <= 1'b0;
      phase_err <= 1'b0;
    end else begin
      rf_we     <= do_wb && wb_en_q;
      illegal   <= do_decode && dec_illegal;
      phase_err <= violation;
    end
  end

  // Saturating count of protocol violations.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       err_cnt <= '0;
    else if (violation && err_cnt != '1) err_cnt <= err_cnt + ERRC_W'(1);
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed testbench for phase_sequencer: drives strobe sequences against a
// small instruction memory and checks hand-computed results after each edge.
module tb_phase_sequencer;

  logic        clk;
  logic        resetn;
  logic        fsm0, fsm1, fsm2, fsm3;
  logic [15:0] imem_data;
  logic [7:0]  imem_addr;
  logic [15:0] ir_q;
  logic [3:0]  rf_ra, rf_rb, rf_wa;
  logic        rf_we;
  logic [1:0]  alu_op;
  logic        imm_sel;
  logic        halted;
  logic        illegal;
  logic        phase_err;
  logic [3:0]  err_cnt;

  logic [15:0] imem [0:255];

  int testsRun = 0;
  int testsFailed = 0;

  assign imem_data = imem[imem_addr];

  phase_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .fsm0      (fsm0),
    .fsm1      (fsm1),
    .fsm2      (fsm2),
    .fsm3      (fsm3),
    .imem_data (imem_data),
    .imem_addr (imem_addr),
    .ir_q      (ir_q),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .alu_op    (alu_op),
    .imm_sel   (imm_sel),
    .halted    (halted),
    .illegal   (illegal),
    .phase_err (phase_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one strobe vector {fsm3,fsm2,fsm1,fsm0} across a rising edge,
  // leaving outputs ready to sample 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] s);
    {fsm3, fsm2, fsm1, fsm0} = s;
    @(posedge clk);
    #1;
    {fsm3, fsm2, fsm1, fsm0} = 4'b0000;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic runPhases();
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    applyStimulus(4'b1000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    {fsm3, fsm2, fsm1, fsm0} = 4'b0000;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    #1;
    checkOutput("rst_pc", 32'(imem_addr), 32'h00);
    checkOutput("rst_ir", 32'(ir_q), 32'h0000);
    checkOutput("rst_we", 32'(rf_we), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_errcnt", 32'(err_cnt), 32'h0);

    // LDI r3,5
    imem[8'h00] = 16'h4305;
    applyStimulus(4'b0001);
    checkOutput("ldi_ir", 32'(ir_q), 32'h4305);
    applyStimulus(4'b0010);
    checkOutput("ldi_wa", 32'(rf_wa), 32'h3);
    checkOutput("ldi_rb", 32'(rf_rb), 32'h5);
    checkOutput("ldi_imm", 32'(imm_sel), 32'h1);
    checkOutput("ldi_alu", 32'(alu_op), 32'h3);
    applyStimulus(4'b0100);
    checkOutput("ldi_we_early", 32'(rf_we), 32'h0);
    applyStimulus(4'b1000);
    checkOutput("ldi_we", 32'(rf_we), 32'h1);
    checkOutput("ldi_pc", 32'(imem_addr), 32'h01);
    applyStimulus(4'b0000);
    checkOutput("ldi_we_off", 32'(rf_we), 32'h0);

    // ADD r1,r2,r3 with a 3-cycle stall before execute
    imem[8'h01] = 16'h1123;
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    checkOutput("add_ra", 32'(rf_ra), 32'h2);
    checkOutput("add_rb", 32'(rf_rb), 32'h3);
    checkOutput("add_wa", 32'(rf_wa), 32'h1);
    checkOutput("add_alu", 32'(alu_op), 32'h0);
    checkOutput("add_imm", 32'(imm_sel), 32'h0);
    repeat (3) applyStimulus(4'b0000);
    applyStimulus(4'b0100);
    checkOutput("add_stall_err", 32'(phase_err), 32'h0);
    applyStimulus(4'b1000);
    checkOutput("add_we", 32'(rf_we), 32'h1);
    checkOutput("add_pc", 32'(imem_addr), 32'h02);
    checkOutput("add_errcnt", 32'(err_cnt), 32'h0);

    // JMP 0xFF, NOP at 0xFF wraps, then JMP 0x5A
    imem[8'h02] = 16'h50FF;
    runPhases();
    checkOutput("jmpff_pc", 32'(imem_addr), 32'hFF);
    checkOutput("jmpff_we", 32'(rf_we), 32'h0);
    imem[8'hFF] = 16'h0000;
    runPhases();
    checkOutput("wrap_pc", 32'(imem_addr), 32'h00);
    checkOutput("wrap_we", 32'(rf_we), 32'h0);
    imem[8'h00] = 16'h505A;
    runPhases();
    checkOutput("jmp5a_pc", 32'(imem_addr), 32'h5A);
    checkOutput("jmp5a_we", 32'(rf_we), 32'h0);

    // Protocol violations
    imem[8'h5A] = 16'h1123;
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    applyStimulus(4'b0010);
    checkOutput("err1_pulse", 32'(phase_err), 32'h1);
    checkOutput("err1_cnt", 32'(err_cnt), 32'h1);
    checkOutput("err1_pc", 32'(imem_addr), 32'h5A);
    checkOutput("err1_we", 32'(rf_we), 32'h0);
    applyStimulus(4'b0000);
    checkOutput("err1_pulse_off", 32'(phase_err), 32'h0);
    applyStimulus(4'b0011);
    checkOutput("err2_pulse", 32'(phase_err), 32'h1);
    checkOutput("err2_cnt", 32'(err_cnt), 32'h2);
    applyStimulus(4'b0001);
    checkOutput("refetch_ok_err", 32'(phase_err), 32'h0);
    applyStimulus(4'b0001);
    checkOutput("err3_pulse", 32'(phase_err), 32'h1);
    checkOutput("err3_cnt", 32'(err_cnt), 32'h3);
    checkOutput("err3_ir", 32'(ir_q), 32'h1123);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    applyStimulus(4'b1000);
    checkOutput("resync_we", 32'(rf_we), 32'h1);
    checkOutput("resync_pc", 32'(imem_addr), 32'h5B);
    checkOutput("resync_err", 32'(phase_err), 32'h0);

    // Illegal opcode then HALT
    imem[8'h5B] = 16'h7000;
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    checkOutput("ill_pulse", 32'(illegal), 32'h1);
    applyStimulus(4'b0100);
    checkOutput("ill_pulse_off", 32'(illegal), 32'h0);
    applyStimulus(4'b1000);
    checkOutput("ill_we", 32'(rf_we), 32'h0);
    checkOutput("ill_pc", 32'(imem_addr), 32'h5C);
    imem[8'h5C] = 16'hF000;
    runPhases();
    checkOutput("halt_flag", 32'(halted), 32'h1);
    checkOutput("halt_pc", 32'(imem_addr), 32'h5C);
    checkOutput("halt_we", 32'(rf_we), 32'h0);
    imem[8'h5C] = 16'h1123;
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    applyStimulus(4'b1111);
    checkOutput("frozen_pc", 32'(imem_addr), 32'h5C);
    checkOutput("frozen_ir", 32'(ir_q), 32'hF000);
    checkOutput("frozen_err", 32'(phase_err), 32'h0);
    checkOutput("frozen_cnt", 32'(err_cnt), 32'h3);
    checkOutput("frozen_halted", 32'(halted), 32'h1);

    // Reset clears halt; then reset asserted during writeback
    resetn = 1'b0;
    #3;
    checkOutput("rst2_halted", 32'(halted), 32'h0);
    checkOutput("rst2_pc", 32'(imem_addr), 32'h00);
    checkOutput("rst2_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk) resetn = 1'b1;
    imem[8'h00] = 16'h1123;
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    {fsm3, fsm2, fsm1, fsm0} = 4'b1000;
    #2 resetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_we", 32'(rf_we), 32'h0);
    checkOutput("midrst_pc", 32'(imem_addr), 32'h00);
    checkOutput("midrst_ir", 32'(ir_q), 32'h0000);
    {fsm3, fsm2, fsm1, fsm0} = 4'b0000;
    @(negedge clk) resetn = 1'b1;
    applyStimulus(4'b0001);
    checkOutput("post_ir", 32'(ir_q), 32'h1123);
    checkOutput("post_fetch_err", 32'(phase_err), 32'h0);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    applyStimulus(4'b1000);
    checkOutput("post_we", 32'(rf_we), 32'h1);
    checkOutput("post_pc", 32'(imem_addr), 32'h01);
    checkOutput("post_cnt", 32'(err_cnt), 32'h0);

    // Saturation of the error counter
    for (int i = 0; i < 15; i++) applyStimulus(4'b1111);
    checkOutput("sat15_cnt", 32'(err_cnt), 32'hF);
    applyStimulus(4'b1111);
    applyStimulus(4'b1111);
    checkOutput("sat17_cnt", 32'(err_cnt), 32'hF);
    checkOutput("sat17_pulse", 32'(phase_err), 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
